// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and mode-sequencing helper for the LED pattern generator.
package led_pattern_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_COUNT    = 2'd0;
  localparam mode_t MODE_EXTERNAL = 2'd1;
  localparam mode_t MODE_SCAN     = 2'd2;
  localparam mode_t MODE_RSVD     = 2'd3;

  // COUNT -> EXTERNAL -> SCAN -> COUNT; the unused encoding falls back to COUNT.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_COUNT:    nxt = MODE_EXTERNAL;
      MODE_EXTERNAL: nxt = MODE_SCAN;
      default:       nxt = MODE_COUNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one async level input.
module edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic pulse
);

  logic sync1_q, sync2_q, dly_q;

  // Synchroniser chain plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  // One-cycle pulse on a synchronised low-to-high transition.
  always_comb begin
    pulse = sync2_q & ~dly_q;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: counting, externally stepped and bouncing-scan patterns with PWM dimming.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NO_OF_LEDS     = 4,
  parameter int unsigned PRESCALE_WIDTH = 8,
  parameter int unsigned PWM_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mode_switch,
  input  logic                      ext_counter,
  input  logic [PRESCALE_WIDTH-1:0] prescale_div,
  input  logic [PWM_WIDTH-1:0]      brightness,
  output logic [NO_OF_LEDS-1:0]     led_out,
  output logic [1:0]                mode_out
);

  localparam logic [NO_OF_LEDS-1:0]     PatOne   = NO_OF_LEDS'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PresOne  = PRESCALE_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0]      PwmOne   = PWM_WIDTH'(1);

  logic                      mode_edge, ext_edge, tick, enable;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PWM_WIDTH-1:0]      pwm_q, pwm_d;
  mode_t                     mode_q, mode_d;
  logic [NO_OF_LEDS-1:0]     pattern_q, pattern_d, led_q, led_d;
  logic                      scan_up_q, scan_up_d;

  edge_sync u_mode_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (mode_switch),
    .pulse    (mode_edge)
  );

  edge_sync u_ext_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (ext_counter),
    .pulse    (ext_edge)
  );

  // Prescaler and PWM counter next state; prescale_div is the tick period minus one.
  always_comb begin
    tick    = (presc_q >= prescale_div);
    presc_d = tick ? '0 : presc_q + PresOne;
    pwm_d   = pwm_q + PwmOne;
    enable  = (pwm_q < brightness) | (&brightness);
    led_d   = pattern_q & {NO_OF_LEDS{enable}};
  end

  // Mode FSM and pattern update; a mode change takes priority over tick/ext steps.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    scan_up_d = scan_up_q;
    if (mode_q == MODE_RSVD) begin
      mode_d    = MODE_COUNT;
      pattern_d = '0;
      scan_up_d = 1'b1;
    end else if (mode_edge) begin
      mode_d    = next_mode(mode_q);
      pattern_d = (mode_d == MODE_SCAN) ? PatOne : '0;
      scan_up_d = 1'b1;
    end else begin
      case (mode_q)
        MODE_COUNT: begin
          if (tick) pattern_d = pattern_q + PatOne;
        end
        MODE_EXTERNAL: begin
          if (ext_edge) pattern_d = pattern_q + PatOne;
        end
        default: begin
          // Bounce between the end bits without dwelling on them.
          if (tick && (NO_OF_LEDS > 1)) begin
            if (scan_up_q) begin
              if (pattern_q[NO_OF_LEDS-1]) begin
                pattern_d = pattern_q >> 1;
                scan_up_d = 1'b0;
              end else begin
                pattern_d = pattern_q << 1;
              end
            end else begin
              if (pattern_q[0]) begin
                pattern_d = pattern_q << 1;
                scan_up_d = 1'b1;
              end else begin
                pattern_d = pattern_q >> 1;
              end
            end
          end
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q   <= '0;
      pwm_q     <= '0;
      mode_q    <= MODE_COUNT;
      pattern_q <= '0;
      scan_up_q <= 1'b1;
      led_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      scan_up_q <= scan_up_d;
      led_q     <= led_d;
    end
  end

  // Registered outputs.
  always_comb begin
    led_out  = led_q;
    mode_out = mode_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues expected outputs by cycle, a monitor checks.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       mode_switch = 1'b1;
  logic       ext_counter = 1'b0;
  logic [7:0] prescale_div = 8'd3;
  logic [3:0] brightness = 4'd15;
  logic [3:0] led_out;
  logic [1:0] mode_out;

  led_pattern_gen #(
    .NO_OF_LEDS     (4),
    .PRESCALE_WIDTH (8),
    .PWM_WIDTH      (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mode_switch  (mode_switch),
    .ext_counter  (ext_counter),
    .prescale_div (prescale_div),
    .brightness   (brightness),
    .led_out      (led_out),
    .mode_out     (mode_out)
  );

  always #5 clk = ~clk;

  // cyc == number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [1:0] mode;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic push(input int c, input logic [3:0] l, input logic [1:0] m, input string nm);
    exp_t e;
    e.cyc  = c;
    e.led  = l;
    e.mode = m;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  // Monitor: compare every queued expectation whose cycle has arrived.
  exp_t cur;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      n_checks++;
      if (cur.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", cur.name, cur.cyc, cyc);
      end else if (led_out !== cur.led || mode_out !== cur.mode) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got led_out=%b mode_out=%0d, expected led_out=%b mode_out=%0d",
                 cur.name, cyc, led_out, mode_out, cur.led, cur.mode);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0, m, c, d, r, s, t0;
    logic [3:0] scan_seq [8];
    logic [3:0] tmp;
    scan_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // Reset held two edges with the async inputs toggling.
    push(1, 4'b0000, 2'd0, "reset_e1");
    push(2, 4'b0000, 2'd0, "reset_e2");
    step(1);
    mode_switch = 1'b0;
    ext_counter = 1'b1;
    step(1);
    ext_counter = 1'b0;
    resetn = 1'b1;
    n0 = cyc;

    // COUNT, prescale_div=3: pattern p lands on led_out at edge n0+4p+1.
    for (int p = 1; p <= 16; p++) begin
      tmp = 4'(p);
      push(n0 + 4 * p + 1, tmp, 2'd0, $sformatf("count_%0d", p));
    end
    wait_cyc(n0 + 65);

    // Enter EXTERNAL; freeze the prescaler for the next phases.
    m = cyc;
    prescale_div = 8'd255;
    push(m + 4, 4'b0000, 2'd1, "ext_enter");
    mode_switch = 1'b1;
    step(2);
    mode_switch = 1'b0;
    step(2);

    for (int i = 1; i <= 3; i++) begin
      c = cyc;
      tmp = 4'(i);
      push(c + 4, tmp, 2'd1, $sformatf("ext_pulse_%0d", i));
      ext_counter = 1'b1;
      step(2);
      ext_counter = 1'b0;
      step(2);
    end

    // Held high for 10 cycles counts once.
    c = cyc;
    push(c + 4, 4'b0100, 2'd1, "ext_hold_inc");
    ext_counter = 1'b1;
    step(10);
    ext_counter = 1'b0;
    step(2);
    push(c + 13, 4'b0100, 2'd1, "ext_hold_once");
    step(2);

    // Simultaneous mode and ext edge: mode change wins, SCAN starts at 0001.
    c = cyc;
    push(c + 4, 4'b0001, 2'd2, "simul_scan");
    push(c + 5, 4'b0001, 2'd2, "simul_hold");
    mode_switch = 1'b1;
    ext_counter = 1'b1;
    step(2);
    mode_switch = 1'b0;
    ext_counter = 1'b0;
    step(4);

    // SCAN with a tick every cycle.
    d = cyc;
    prescale_div = 8'd0;
    for (int t = 0; t < 8; t++) push(d + 1 + t, scan_seq[t], 2'd2, $sformatf("scan_%0d", t));
    push(d + 15, 4'b0100, 2'd2, "scan_pre_reset");
    wait_cyc(d + 15);

    // Reset mid-SCAN while showing 0100.
    r = cyc;
    resetn = 1'b0;
    push(r + 1, 4'b0000, 2'd0, "midreset_e1");
    push(r + 2, 4'b0000, 2'd0, "midreset_e2");
    step(2);
    resetn = 1'b1;
    push(r + 3, 4'b0000, 2'd0, "restart_0");
    push(r + 4, 4'b0001, 2'd0, "restart_1");
    push(r + 5, 4'b0010, 2'd0, "restart_2");

    // Freeze COUNT at 1111, then dim: PWM phase is (edge - r - 3) mod 16.
    wait_cyc(r + 17);
    s = cyc;
    prescale_div = 8'd255;
    brightness = 4'd4;
    for (int e = s + 1; e <= s + 32; e++) begin
      tmp = (((e - r - 3) % 16) < 4) ? 4'b1111 : 4'b0000;
      push(e, tmp, 2'd0, $sformatf("pwm4_%0d", e - s));
    end
    wait_cyc(s + 32);
    t0 = cyc;
    brightness = 4'd0;
    for (int e = t0 + 1; e <= t0 + 16; e++) push(e, 4'b0000, 2'd0, $sformatf("pwm0_%0d", e - t0));
    wait_cyc(t0 + 17);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", cur.name, cur.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
